// File: rtl/dbus_rr_arbiter_if.sv
// dbus request/response types and the bundle shared by the arbiter.
// Ports: ireqs/iresps (requester side), oreq/oresp (downstream side).
package dbus_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

interface dbus_rr_arbiter_if #(
  parameter int NUM_REQ = 2
) ();
  import dbus_pkg::*;

  dbus_req_t  [NUM_REQ-1:0] ireqs;
  dbus_resp_t [NUM_REQ-1:0] iresps;
  dbus_req_t                oreq;
  dbus_resp_t               oresp;

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq
  );

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq
  );
endinterface

// File: rtl/dbus_rr_arbiter.sv
// Round-robin arbiter sharing one dbus port among NUM_REQ requesters.
// Ports: clk, reset (sync, high), bus (slave), busy, grant_idx.
module dbus_rr_arbiter
  import dbus_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  bit FIXED_PRIO = 1'b0,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  dbus_rr_arbiter_if.slave    bus,
  output logic                busy,
  output logic [IW-1:0]       grant_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;

  logic [NUM_REQ-1:0] vld;
  logic               any;
  logic [IW-1:0]      sel;
  int                 idx;

  dbus_req_t                oreq_c;
  dbus_resp_t [NUM_REQ-1:0] iresps_c;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      vld[i] = bus.ireqs[i].valid;
    end
  end

  // Scan starts one past the last completed winner,
  // so a completion hands priority to the next index.
  always_comb begin
    any = 1'b0;
    sel = '0;
    idx = 0;
    if (FIXED_PRIO) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any && vld[i]) begin
          any = 1'b1;
          sel = IW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(last_q) + k) % NUM_REQ;
        if (!any && vld[idx]) begin
          any = 1'b1;
          sel = IW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (any) begin
          if (bus.oresp.addr_ok
              && bus.oresp.data_ok) begin
            last_d = sel;
          end else begin
            grant_d = sel;
            state_d = bus.oresp.addr_ok
                      ? S_DATA : S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (bus.oresp.addr_ok
            && bus.oresp.data_ok) begin
          state_d = S_IDLE;
          last_d  = grant_q;
        end else if (bus.oresp.addr_ok) begin
          state_d = S_DATA;
        end else if (!vld[grant_q]) begin
          // withdrawn request: no completion,
          // so priority order is left alone
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (bus.oresp.data_ok) begin
          state_d = S_IDLE;
          last_d  = grant_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // oreq depends only on state and ireqs,
  // never on oresp.
  always_comb begin
    oreq_c   = '0;
    iresps_c = '0;
    unique case (state_q)
      S_IDLE: begin
        if (any) begin
          oreq_c        = bus.ireqs[sel];
          iresps_c[sel] = bus.oresp;
        end
      end
      S_ADDR: begin
        oreq_c            = bus.ireqs[grant_q];
        iresps_c[grant_q] = bus.oresp;
      end
      S_DATA: begin
        iresps_c[grant_q].data_ok =
          bus.oresp.data_ok;
        iresps_c[grant_q].data =
          bus.oresp.data;
      end
      default: begin
        oreq_c = '0;
      end
    endcase
  end

  assign bus.oreq   = oreq_c;
  assign bus.iresps = iresps_c;
  assign busy       = (state_q != S_IDLE);
  assign grant_idx  = busy ? grant_q : '0;

  a_no_issue_in_data: assert property (
    @(posedge clk) disable iff (reset)
    (state_q == S_DATA) |-> !bus.oreq.valid
  );

endmodule

// File: tb/tb_dbus_rr_arbiter.sv
// Bench for dbus_rr_arbiter: vector table plus scoreboard queue.
// Second instance covers fixed-priority starvation.
module tb_dbus_rr_arbiter;
  import dbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy, busy_fp;
  logic [0:0] gidx, gidx_fp;

  dbus_rr_arbiter_if #(.NUM_REQ(2)) bus ();
  dbus_rr_arbiter_if #(.NUM_REQ(2)) bus_fp ();

  dbus_rr_arbiter #(
    .NUM_REQ(2),
    .FIXED_PRIO(1'b0)
  ) u_rr (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .busy(busy),
    .grant_idx(gidx)
  );

  dbus_rr_arbiter #(
    .NUM_REQ(2),
    .FIXED_PRIO(1'b1)
  ) u_fp (
    .clk(clk),
    .reset(reset),
    .bus(bus_fp.slave),
    .busy(busy_fp),
    .grant_idx(gidx_fp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit v0;
    bit v1;
    bit aok;
    bit dok;
    bit ebusy;
    bit egi;
    int esrc;
    int ert;
    bit eaok;
    bit edok;
  } vec_t;

  typedef struct {
    logic       busy;
    logic       gi;
    dbus_req_t  oreq;
    dbus_resp_t r0;
    dbus_resp_t r1;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   errs = 0;
  int   checks = 0;

  function automatic dbus_req_t req_of(int k, bit v);
    dbus_req_t r;
    r.valid  = v;
    r.addr   = (k == 0) ? 32'h8000_0010 : 32'h8000_0020;
    r.size   = 3'd2;
    r.strobe = (k == 0) ? 4'h0 : 4'hF;
    r.data   = (k == 0) ? 32'h0 : 32'hCAFE_0001;
    return r;
  endfunction

  function automatic vec_t mk(
    bit rst, bit v0, bit v1, bit aok, bit dok,
    bit ebusy, bit egi, int esrc, int ert,
    bit eaok, bit edok);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1;
    v.aok = aok; v.dok = dok;
    v.ebusy = ebusy; v.egi = egi;
    v.esrc = esrc; v.ert = ert;
    v.eaok = eaok; v.edok = edok;
    return v;
  endfunction

  task automatic check(
    input string      tag,
    input logic       b,
    input logic       g,
    input dbus_req_t  o,
    input dbus_resp_t r0,
    input dbus_resp_t r1);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (b !== e.busy) begin
      errs++;
      $display("FAIL %s busy got %0b want %0b",
               tag, b, e.busy);
    end
    checks++;
    if (g !== e.gi) begin
      errs++;
      $display("FAIL %s grant_idx got %0b want %0b",
               tag, g, e.gi);
    end
    checks++;
    if (o !== e.oreq) begin
      errs++;
      $display("FAIL %s oreq got %h want %h",
               tag, o, e.oreq);
    end
    checks++;
    if (r0 !== e.r0 || r1 !== e.r1) begin
      errs++;
      $display("FAIL %s iresps got %h/%h want %h/%h",
               tag, r0, r1, e.r0, e.r1);
    end
  endtask

  task automatic run_row(input int i, input vec_t v);
    exp_t       e;
    dbus_resp_t rs;
    string      tag;
    rs = {v.aok, v.dok, 32'h1000_0000 + 32'(i)};
    reset           = v.rst;
    bus.ireqs[0]    = req_of(0, v.v0);
    bus.ireqs[1]    = req_of(1, v.v1);
    bus.oresp       = rs;
    e.busy = v.ebusy;
    e.gi   = v.egi;
    if (v.esrc < 0)
      e.oreq = '0;
    else
      e.oreq = req_of(v.esrc,
                      (v.esrc == 0) ? v.v0 : v.v1);
    e.r0 = (v.ert == 0)
           ? {v.eaok, v.edok, rs.data} : '0;
    e.r1 = (v.ert == 1)
           ? {v.eaok, v.edok, rs.data} : '0;
    exp_q.push_back(e);
    @(negedge clk);
    tag = $sformatf("row%0d", i);
    check(tag, busy, gidx[0], bus.oreq,
          bus.iresps[0], bus.iresps[1]);
    @(posedge clk);
    #1;
  endtask

  task automatic fp_cycle(
    input int t, input bit aok, input bit dok,
    input bit ebusy);
    exp_t       e;
    dbus_resp_t rs;
    rs = {aok, dok, 32'h2000_0000 + 32'(t)};
    bus_fp.oresp = rs;
    e.busy = ebusy;
    e.gi   = 1'b0;
    e.oreq = req_of(0, 1'b1);
    e.r0   = rs;
    e.r1   = '0;
    exp_q.push_back(e);
    @(negedge clk);
    check($sformatf("fixed%0d", t), busy_fp,
          gidx_fp[0], bus_fp.oreq,
          bus_fp.iresps[0], bus_fp.iresps[1]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    bus.ireqs    = '0;
    bus.oresp    = '0;
    bus_fp.ireqs = '0;
    bus_fp.oresp = '0;

    // rst v0 v1 aok dok | busy gi src rt eaok edok
    // reset state
    tbl.push_back(mk(0,0,0,0,0, 0,0,-1,-1,0,0));
    // single-cycle completion from IDLE
    tbl.push_back(mk(0,1,0,1,1, 0,0, 0, 0,1,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,-1,-1,0,0));
    // alternation 0,1,0
    tbl.push_back(mk(1,0,0,0,0, 0,0,-1,-1,0,0));
    tbl.push_back(mk(0,1,1,0,0, 0,0, 0, 0,0,0));
    tbl.push_back(mk(0,1,1,1,0, 1,0, 0, 0,1,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,-1, 0,0,0));
    tbl.push_back(mk(0,1,1,0,1, 1,0,-1, 0,0,1));
    tbl.push_back(mk(0,1,1,0,0, 0,0, 1, 1,0,0));
    tbl.push_back(mk(0,1,1,1,0, 1,1, 1, 1,1,0));
    tbl.push_back(mk(0,1,1,0,0, 1,1,-1, 1,0,0));
    tbl.push_back(mk(0,1,1,0,1, 1,1,-1, 1,0,1));
    tbl.push_back(mk(0,1,1,0,0, 0,0, 0, 0,0,0));
    tbl.push_back(mk(0,1,1,1,0, 1,0, 0, 0,1,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,-1, 0,0,0));
    tbl.push_back(mk(0,1,1,0,1, 1,0,-1, 0,0,1));
    // req1 in DATA blocks waiting req0
    tbl.push_back(mk(0,0,1,0,0, 0,0, 1, 1,0,0));
    tbl.push_back(mk(0,0,1,1,0, 1,1, 1, 1,1,0));
    tbl.push_back(mk(0,1,0,0,0, 1,1,-1, 1,0,0));
    tbl.push_back(mk(0,1,0,0,1, 1,1,-1, 1,0,1));
    tbl.push_back(mk(0,1,0,1,1, 0,0, 0, 0,1,1));
    // withdrawal in ADDR keeps last
    tbl.push_back(mk(1,0,0,0,0, 0,0,-1,-1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0, 0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0, 0, 0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 0,0, 0, 0,0,0));
    tbl.push_back(mk(0,1,1,1,1, 1,0, 0, 0,1,1));
    // reset while in DATA
    tbl.push_back(mk(0,1,1,0,0, 0,0, 1, 1,0,0));
    tbl.push_back(mk(0,1,1,1,0, 1,1, 1, 1,1,0));
    tbl.push_back(mk(1,1,1,0,0, 1,1,-1, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,-1,-1,0,0));
    tbl.push_back(mk(0,1,1,0,0, 0,0, 0, 0,0,0));
    // reset while in ADDR
    tbl.push_back(mk(1,1,1,0,0, 1,0, 0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,-1,-1,0,0));

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      run_row(i, tbl[i]);
    end

    // fixed priority: both always valid,
    // requester 0 takes every transaction
    bus.ireqs       = '0;
    bus.oresp       = '0;
    bus_fp.ireqs[0] = req_of(0, 1'b1);
    bus_fp.ireqs[1] = req_of(1, 1'b1);
    for (int t = 0; t < 4; t++) begin
      fp_cycle(2 * t, 1'b0, 1'b0, 1'b0);
      fp_cycle(2 * t + 1, 1'b1, 1'b1, 1'b1);
    end
    bus_fp.ireqs = '0;
    bus_fp.oresp = '0;

    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain %0d entries left want 0",
               exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
